// File: rtl/fir_frame_collector.sv
`timescale 1ns/1ps
// fir_frame_collector
// Collects the FIR output stream into N-sample frames held in a two-bank
// (ping-pong) buffer. Each complete frame goes to the FFT stage in parallel
// over a valid/ready handshake. The FIR side cannot be stalled, so a sample
// whose target bank is still occupied is dropped and a sticky overflow flag
// is raised. A run ends once FRAMES frames have been handed off.
module fir_frame_collector #(
  parameter int W      = 16,
  parameter int N      = 16,
  parameter int FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fir_valid,
  input  logic signed [W-1:0] fir_d,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [N*W-1:0]      frame_data,
  output logic [5:0]          frame_idx,
  output logic                overflow,
  output logic                done
);

  localparam int         CW        = $clog2(N);
  localparam logic [6:0] FRAMES_M1 = 7'(FRAMES - 1);
  localparam logic [5:0] IDX_LAST  = 6'(FRAMES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t                     state;
  // Packed so that bank[b] flattens to sample k at bits [k*W +: W].
  logic [1:0][N-1:0][W-1:0]   bank;
  logic                       wr_bank;
  logic                       rd_bank;
  logic [CW-1:0]              wr_cnt;
  logic [1:0]                 full;
  logic [1:0]                 full_nxt;
  logic [6:0]                 frames_in;

  logic wr_en;
  logic wr_ok;
  logic wr_last;
  logic xfer;
  logic last_xfer;

  // Writes are only accepted while frames of the current run remain to be filled.
  assign wr_en     = fir_valid && (state == FILL);
  assign wr_ok     = wr_en && !full[wr_bank];
  assign wr_last   = wr_ok && (wr_cnt == CNT_LAST);
  assign xfer      = frame_valid && frame_ready;
  assign last_xfer = xfer && (frame_idx == IDX_LAST);

  assign frame_valid = full[rd_bank];
  assign frame_data  = bank[rd_bank];

  // Bank occupancy: freeing the read bank and completing the write bank never
  // touch the same bank, since a write needs its bank empty and a read needs it full.
  always_comb begin
    full_nxt = full;
    if (xfer)
      full_nxt[rd_bank] = 1'b0;
    if (wr_last)
      full_nxt[wr_bank] = 1'b1;
  end

  // Sample storage: bit-exact copy of the accepted FIR samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bank <= '0;
    else if (wr_ok)
      bank[wr_bank][wr_cnt] <= fir_d;
  end

  // Control FSM with write/read pointers, flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      full      <= '0;
      frames_in <= '0;
      frame_idx <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_en && full[wr_bank])
        overflow <= 1'b1;

      if (wr_ok) begin
        if (wr_last) begin
          wr_cnt    <= '0;
          wr_bank   <= ~wr_bank;
          frames_in <= frames_in + 7'd1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (xfer) begin
        rd_bank   <= ~rd_bank;
        frame_idx <= (frame_idx == IDX_LAST) ? 6'd0 : frame_idx + 6'd1;
      end

      if (last_xfer)
        done <= 1'b1;

      case (state)
        FILL:    if (wr_last && (frames_in == FRAMES_M1)) state <= DRAIN;
        DRAIN:   if (last_xfer) state <= DONE;
        DONE:    state <= DONE;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_collector.sv
`timescale 1ns/1ps
// Testbench for fir_frame_collector: frames are predicted by a scoreboard
// fed from the driven stimulus and compared when the DUT hands them off.
module tb_fir_frame_collector;

  localparam int W      = 16;
  localparam int N      = 16;
  localparam int FRAMES = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic                fv;
  logic signed [W-1:0] fd;
  logic                fr;
  logic                frame_valid;
  logic [N*W-1:0]      frame_data;
  logic [5:0]          frame_idx;
  logic                overflow;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N*W-1:0] data;
    logic [5:0]     idx;
  } exp_t;

  exp_t           q[$];
  exp_t           m_e;
  logic [N*W-1:0] pbuf;
  int             pcnt;
  int             fin_m;
  int             hs_cnt;
  int             m_pend;

  fir_frame_collector #(.W(W), .N(N), .FRAMES(FRAMES)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fv),
    .fir_d       (fd),
    .frame_valid (frame_valid),
    .frame_ready (fr),
    .frame_data  (frame_data),
    .frame_idx   (frame_idx),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Scoreboard: at the negedge the inputs for the coming posedge are stable.
  // A sample is accepted unless two completed frames are waiting (pre-edge).
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pbuf   = '0;
      pcnt   = 0;
      fin_m  = 0;
      hs_cnt = 0;
    end else begin
      m_pend = q.size();
      n_checks++;
      if (frame_valid !== (m_pend != 0)) begin
        n_fail++;
        $display("FAIL frame_valid: got %b want %b at %0t", frame_valid, (m_pend != 0), $time);
      end
      if (frame_valid === 1'b1 && fr) begin
        n_checks++;
        if (m_pend == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got idx %0d want no frame", frame_idx);
        end else begin
          m_e = q.pop_front();
          hs_cnt++;
          if (frame_data !== m_e.data || frame_idx !== m_e.idx) begin
            n_fail++;
            $display("FAIL frame: got idx %0d data %h want idx %0d data %h",
                     frame_idx, frame_data, m_e.idx, m_e.data);
          end
        end
      end
      if (fv && fin_m < FRAMES && m_pend < 2) begin
        pbuf[pcnt*W +: W] = fd;
        pcnt++;
        if (pcnt == N) begin
          m_e.data = pbuf;
          m_e.idx  = 6'(fin_m);
          q.push_back(m_e);
          fin_m++;
          pcnt = 0;
        end
      end
    end
  end

  // One clock: inputs set at posedge+1, consumed at the next posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    fv = v;
    fd = d;
    fr = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fv  = 1'b0;
    fd  = '0;
    fr  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (frame_valid !== 1'b0 || frame_data !== '0 || frame_idx !== 6'd0 ||
        overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b idx=%0d ovf=%b done=%b data=%h want all zero",
               frame_valid, frame_idx, overflow, done, frame_data);
    end
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < N - 1; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: got %b want 0", frame_valid);
    end
    step(1'b1, 16'h010F, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid: got %b want 1", frame_valid);
    end
    n_checks++;
    if (frame_data[15:0] !== 16'h0100 || frame_data[255:240] !== 16'h010F) begin
      n_fail++;
      $display("FAIL single_data: got first %h last %h want 0100 010f",
               frame_data[15:0], frame_data[255:240]);
    end
    n_checks++;
    if (frame_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL single_idx: got %0d want 0", frame_idx);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b0 || frame_idx !== 6'd1) begin
      n_fail++;
      $display("FAIL single_after: got v=%b idx=%0d want v=0 idx=1", frame_valid, frame_idx);
    end
  endtask

  task automatic test_streaming();
    int waited;
    do_reset();
    for (int i = 0; i < N * FRAMES; i++) step(1'b1, 16'(i * 37 + 16'h0A05), 1'b1);
    waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      step(1'b0, '0, 1'b1);
      waited++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_done: got %b want 1 (timeout)", done);
    end
    n_checks++;
    if (hs_cnt !== FRAMES) begin
      n_fail++;
      $display("FAIL stream_count: got %0d frames want %0d", hs_cnt, FRAMES);
    end
    n_checks++;
    if (overflow !== 1'b0 || frame_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL stream_flags: got ovf=%b idx=%0d want ovf=0 idx=0", overflow, frame_idx);
    end
  endtask

  task automatic test_post_run();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h5A5A, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, 16'(i), 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL post_run: got v=%b ovf=%b done=%b want v=0 ovf=0 done=1",
               frame_valid, overflow, done);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_ovf_yet: got %b want 0", overflow);
    end
    step(1'b1, 16'hC020, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ovf: got %b want 1", overflow);
    end
    for (int i = 2 * N + 1; i < 40; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b0 || frame_idx !== 6'd2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drained: got v=%b idx=%0d ovf=%b want v=0 idx=2 ovf=1",
               frame_valid, frame_idx, overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0);
    fv = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (frame_valid !== 1'b0 || frame_data !== '0 || frame_idx !== 6'd0 ||
        overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b idx=%0d ovf=%b done=%b data=%h want all zero",
               frame_valid, frame_idx, overflow, done, frame_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) step(1'b1, 16'h4400 + 16'(i), 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_idx !== 6'd0 || frame_data[15:0] !== 16'h4400) begin
      n_fail++;
      $display("FAIL reset_restart: got v=%b idx=%0d first=%h want v=1 idx=0 first=4400",
               frame_valid, frame_idx, frame_data[15:0]);
    end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_same_edge();
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0);
    step(1'b1, 16'h7ABC, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || frame_idx !== 6'd1) begin
      n_fail++;
      $display("FAIL same_edge_drop: got ovf=%b idx=%0d want ovf=1 idx=1", overflow, frame_idx);
    end
    step(1'b1, 16'h1234, 1'b0);
    for (int i = 1; i < N; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_idx !== 6'd2 ||
        frame_data[15:0] !== 16'h1234 || frame_data[31:16] !== 16'h3001) begin
      n_fail++;
      $display("FAIL same_edge_slot0: got v=%b idx=%0d s0=%h s1=%h want v=1 idx=2 s0=1234 s1=3001",
               frame_valid, frame_idx, frame_data[15:0], frame_data[31:16]);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_empty: got %b want 0", frame_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_streaming();
    test_post_run();
    test_backpressure();
    test_reset_mid();
    test_same_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
